// File: rtl/spi_master.sv
// spi_master: initiator side of the SPI memory link.
// Runs one 16-bit frame {addr[6:0], rw, data[7:0]}, MSB first, per accepted start.
// SCLK idles low, MOSI changes on SCLK falling edges, MISO is sampled at the end of
// each SCLK high phase. All pin and status outputs come straight from registers.
`timescale 1ns/1ps
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk_pin,
  output logic       cs_pin,
  output logic       mosi_pin,
  input  logic       miso_pin
);

  // Half-period counter width; CLK_DIV=1 still needs a 1-bit counter that stays at 0.
  localparam int HC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_HOLD,
    S_GAP
  } state_t;

  state_t            state_q;
  logic [HC_W-1:0]   hc_q;
  logic [HC_W-1:0]   hc_d;
  logic              half_last;
  logic [3:0]        bit_q;
  // Frame bits 14..0 still to be driven; bit 15 goes straight to MOSI at start.
  logic [14:0]       tx_q;
  logic [7:0]        rx_q;
  logic              rw_q;
  logic              sclk_q;
  logic              cs_q;
  logic              mosi_q;
  logic              busy_q;
  logic              done_q;
  logic [7:0]        rdata_q;

  // Half-period counter next value: wraps to zero when a phase completes.
  always_comb begin
    half_last = (hc_q == HC_LAST);
    hc_d      = half_last ? '0 : hc_q + 1'b1;
  end

  // Frame sequencer with registered pin and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      hc_q    <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rw_q    <= 1'b0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          hc_q  <= '0;
          bit_q <= '0;
          if (start) begin
            // Reads shift out zeros in the data phase.
            tx_q    <= {addr[5:0], rw, (rw ? 8'h00 : wdata)};
            rw_q    <= rw;
            cs_q    <= 1'b0;
            busy_q  <= 1'b1;
            mosi_q  <= addr[6];
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          hc_q <= hc_d;
          if (half_last) begin
            sclk_q  <= 1'b1;
            state_q <= S_HIGH;
          end
        end
        S_HIGH: begin
          hc_q <= hc_d;
          if (half_last) begin
            rx_q   <= {rx_q[6:0], miso_pin};
            sclk_q <= 1'b0;
            if (bit_q == 4'd15) begin
              mosi_q  <= 1'b0;
              state_q <= S_HOLD;
            end else begin
              bit_q   <= bit_q + 4'd1;
              mosi_q  <= tx_q[14];
              tx_q    <= {tx_q[13:0], 1'b0};
              state_q <= S_LOW;
            end
          end
        end
        S_LOW: begin
          hc_q <= hc_d;
          if (half_last) begin
            sclk_q  <= 1'b1;
            state_q <= S_HIGH;
          end
        end
        S_HOLD: begin
          hc_q <= hc_d;
          if (half_last) begin
            cs_q   <= 1'b1;
            done_q <= 1'b1;
            // After 16 shifts rx_q holds the samples from SCLK rises 9..16.
            if (rw_q) begin
              rdata_q <= rx_q;
            end
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          hc_q <= hc_d;
          if (half_last) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign sclk_pin = sclk_q;
  assign cs_pin   = cs_q;
  assign mosi_pin = mosi_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed checks of spi_master at CLK_DIV=4 and CLK_DIV=1.
`timescale 1ns/1ps
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  // CLK_DIV=4 instance signals
  logic       start4, rw4, miso4;
  logic [6:0] addr4;
  logic [7:0] wdata4;
  logic       busy4, done4, sclk4, cs4, mosi4;
  logic [7:0] rdata4;

  // CLK_DIV=1 instance signals
  logic       start1, rw1, miso1;
  logic [6:0] addr1;
  logic [7:0] wdata1;
  logic       busy1, done1, sclk1, cs1, mosi1;
  logic [7:0] rdata1;

  spi_master #(.CLK_DIV(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .addr(addr4), .rw(rw4),
    .wdata(wdata4), .busy(busy4), .done(done4), .rdata(rdata4),
    .sclk_pin(sclk4), .cs_pin(cs4), .mosi_pin(mosi4), .miso_pin(miso4)
  );

  spi_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .addr(addr1), .rw(rw1),
    .wdata(wdata1), .busy(busy1), .done(done1), .rdata(rdata1),
    .sclk_pin(sclk1), .cs_pin(cs1), .mosi_pin(mosi1), .miso_pin(miso1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // MOSI captured on every SCLK rising edge of the CLK_DIV=4 instance
  logic [15:0] cap4;
  int          rises4;
  logic [7:0]  slave_byte;

  always @(posedge sclk4) begin
    cap4   = {cap4[14:0], mosi4};
    rises4 = rises4 + 1;
  end

  // Behavioural slave: drives slave_byte MSB first on falling edges after the 8th rise
  always @(negedge sclk4) begin
    if (rises4 >= 8 && rises4 <= 15) miso4 = slave_byte[15 - rises4];
  end

  // One start on the CLK_DIV=4 instance; cycles counted from the accepting edge.
  task automatic run_frame(input logic [6:0] a, input logic r, input logic [7:0] w,
                           input logic repulse,
                           output int done_cyc, output int busy_cyc, output int n_done);
    logic pulsed;
    cap4   = '0;
    rises4 = 0;
    addr4  = a;
    rw4    = r;
    wdata4 = w;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    addr4  = ~a;
    rw4    = ~r;
    wdata4 = ~w;
    done_cyc = 0;
    busy_cyc = 0;
    n_done   = 0;
    pulsed   = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (done4) begin
        n_done++;
        if (done_cyc == 0) done_cyc = n;
      end
      if (!busy4 && busy_cyc == 0) busy_cyc = n;
      if (repulse && rises4 == 5 && !pulsed) begin
        start4 = 1'b1;
        addr4  = 7'h7E;
        pulsed = 1'b1;
      end else begin
        start4 = 1'b0;
      end
    end
  endtask

  initial begin
    int dc, bc, nd, found, cs_hi, nd1;
    int d1 [3];

    reset_n = 1'b0;
    start4 = 1'b0; rw4 = 1'b0; addr4 = '0; wdata4 = '0; miso4 = 1'b0;
    start1 = 1'b0; rw1 = 1'b0; addr1 = '0; wdata1 = '0; miso1 = 1'b0;
    cap4 = '0; rises4 = 0; slave_byte = '0;

    // 1. Reset held with start toggling
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      start4 = ~start4;
      start1 = ~start1;
      addr4  = 7'h55;
    end
    check_val("rst_cs", {31'd0, cs4}, 32'd1);
    check_val("rst_sclk", {31'd0, sclk4}, 32'd0);
    check_val("rst_mosi", {31'd0, mosi4}, 32'd0);
    check_val("rst_busy", {31'd0, busy4}, 32'd0);
    check_val("rst_done", {31'd0, done4}, 32'd0);
    check_val("rst_rdata", {24'd0, rdata4}, 32'd0);
    check_val("rst_rises", rises4, 32'd0);
    check_val("rst_cs1", {31'd0, cs1}, 32'd1);
    start4 = 1'b0;
    start1 = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 2. Write 7'h15 / 8'hA5
    run_frame(7'h15, 1'b0, 8'hA5, 1'b0, dc, bc, nd);
    check_val("wr_frame", {16'd0, cap4}, 32'h2AA5);
    check_val("wr_rises", rises4, 32'd16);
    check_val("wr_done_cyc", dc, 32'd132);
    check_val("wr_busy_fall", bc, 32'd136);
    check_val("wr_ndone", nd, 32'd1);
    check_val("wr_rdata", {24'd0, rdata4}, 32'd0);

    // 3. Read 7'h7F with slave returning 8'h3C
    slave_byte = 8'h3C;
    run_frame(7'h7F, 1'b1, 8'hC3, 1'b0, dc, bc, nd);
    check_val("rd_hdr", {24'd0, cap4[15:8]}, 32'hFF);
    check_val("rd_mosi_data", {24'd0, cap4[7:0]}, 32'h00);
    check_val("rd_rdata", {24'd0, rdata4}, 32'h3C);
    check_val("rd_done_cyc", dc, 32'd132);

    // 4. Second start at bit 5 is ignored
    miso4 = 1'b0;
    slave_byte = 8'h00;
    run_frame(7'h01, 1'b0, 8'h42, 1'b1, dc, bc, nd);
    check_val("busy_rises", rises4, 32'd16);
    check_val("busy_addr", {25'd0, cap4[15:9]}, 32'h01);
    check_val("busy_ndone", nd, 32'd1);
    check_val("busy_rdata_held", {24'd0, rdata4}, 32'h3C);

    // 5. Reset during bit 7, then a clean write
    cap4   = '0;
    rises4 = 0;
    addr4  = 7'h11;
    rw4    = 1'b0;
    wdata4 = 8'hF0;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    found  = 0;
    for (int n = 0; n < 200; n++) begin
      if (rises4 >= 7) begin
        found = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check_val("mid_reach_bit7", found, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("mid_cs", {31'd0, cs4}, 32'd1);
    check_val("mid_sclk", {31'd0, sclk4}, 32'd0);
    check_val("mid_busy", {31'd0, busy4}, 32'd0);
    check_val("mid_rdata", {24'd0, rdata4}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame(7'h33, 1'b0, 8'h5A, 1'b0, dc, bc, nd);
    check_val("post_frame", {16'd0, cap4}, 32'h665A);
    check_val("post_rises", rises4, 32'd16);
    check_val("post_done_cyc", dc, 32'd132);

    // 6. Back-to-back frames at CLK_DIV=1 with start held high
    addr1  = 7'h2B;
    rw1    = 1'b0;
    wdata1 = 8'h99;
    start1 = 1'b1;
    nd1    = 0;
    cs_hi  = 0;
    d1[0] = 0; d1[1] = 0; d1[2] = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (done1) begin
        if (nd1 < 3) d1[nd1] = n;
        nd1++;
      end
      if (nd1 == 1 && cs1) cs_hi++;
      if (nd1 >= 3) start1 = 1'b0;
    end
    check_val("b2b_ndone", nd1, 32'd3);
    check_val("b2b_gap01", d1[1] - d1[0], 32'd35);
    check_val("b2b_gap12", d1[2] - d1[1], 32'd35);
    check_val("b2b_cs_high", cs_hi, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
